// File: rtl/syscall_console.sv
// syscall_console: responder for the CPU SYSCALL halt/GO handshake.
// Latches the CPU display word on each halt entry and shows it on an 8-digit
// multiplexed seven-segment display. A debounced press of btn_go returns a
// single-cycle GO pulse. Optional auto-continue timer: CONSOLE_AUTO_RUN_EN.
module syscall_console #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_WAIT       = 50000000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        halt,
  input  logic [31:0] display,
  input  logic        btn_go,
  input  logic        auto_mode,
  output logic        GO,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [31:0] shown,
  output logic [15:0] halt_count
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALTED    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_WAIT_DROP = 2'd3
  } state_t;

  state_t             state_r, next_state_s;
  logic               sync1_r, sync2_r;
  logic               db_r, db_d_r;
  logic [DEB_W-1:0]   db_cnt_r;
  logic               press_s, expire_s, capture_s, go_next_s;
  logic               go_r;
  logic [31:0]        shown_r;
  logic [15:0]        halt_count_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [2:0]         scan_idx_r;
  logic [7:0]         seg_r, an_r;

  // Active-low hex decode, dp always off.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  4'hF: hex7 = 8'h8E;
      default: hex7 = 8'hFF;
    endcase
  endfunction

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_go;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      db_r     <= 1'b0;
      db_d_r   <= 1'b0;
      db_cnt_r <= {DEB_W{1'b0}};
    end else begin
      db_d_r <= db_r;
      if (sync2_r != db_r) begin
        if (db_cnt_r == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_r     <= sync2_r;
          db_cnt_r <= {DEB_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + 1'b1;
        end
      end else begin
        db_cnt_r <= {DEB_W{1'b0}};
      end
    end
  end

  assign press_s = db_r & ~db_d_r;

`ifdef CONSOLE_AUTO_RUN_EN
  localparam int AUTO_W = (AUTO_WAIT > 1) ? $clog2(AUTO_WAIT) : 1;
  logic [AUTO_W-1:0] auto_cnt_r;

  assign expire_s = (state_r == ST_HALTED) && auto_mode &&
                    (auto_cnt_r == AUTO_W'(AUTO_WAIT - 1));

  // Auto-run timer: counts only while parked in HALTED with auto_mode set.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if ((state_r == ST_HALTED) && auto_mode && (next_state_s == ST_HALTED)) begin
      auto_cnt_r <= auto_cnt_r + 1'b1;
    end else begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end
  end
`else
  logic unused_auto_s;
  assign unused_auto_s = auto_mode;
  assign expire_s      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN:       if (halt) next_state_s = ST_HALTED; else next_state_s = ST_RUN;
      ST_HALTED:    if (press_s || expire_s) next_state_s = ST_RELEASE; else next_state_s = ST_HALTED;
      ST_RELEASE:   next_state_s = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!halt) next_state_s = ST_RUN; else next_state_s = ST_WAIT_DROP;
      default:      next_state_s = ST_RUN;
    endcase
  end

  // FSM output decode: capture strobe and next-cycle GO level.
  always_comb begin
    capture_s = 1'b0;
    go_next_s = 1'b0;
    case (state_r)
      ST_RUN:    begin capture_s = halt; go_next_s = 1'b0; end
      ST_HALTED: begin capture_s = 1'b0; go_next_s = (next_state_s == ST_RELEASE); end
      default:   begin capture_s = 1'b0; go_next_s = 1'b0; end
    endcase
  end

  // Registered GO, display latch and halt-entry counter.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      go_r         <= 1'b0;
      shown_r      <= 32'h0000_0000;
      halt_count_r <= 16'h0000;
    end else begin
      go_r <= go_next_s;
      if (capture_s) begin
        shown_r      <= display;
        halt_count_r <= halt_count_r + 16'h0001;
      end
    end
  end

  // Digit scan timer and index.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      scan_idx_r <= 3'd0;
    end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      scan_idx_r <= scan_idx_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 1'b1;
    end
  end

  // Registered digit enable and segment pattern, updated on the same edge.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      an_r  <= 8'hFE;
      seg_r <= 8'hC0;
    end else begin
      an_r  <= ~(8'd1 << scan_idx_r);
      seg_r <= hex7(shown_r[{scan_idx_r, 2'b00} +: 4]);
    end
  end

  assign GO         = go_r;
  assign shown      = shown_r;
  assign halt_count = halt_count_r;
  assign seg        = seg_r;
  assign an         = an_r;

endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console (SCAN_DIV=4, DEBOUNCE_CYCLES=3, AUTO_WAIT=10).
module tb_syscall_console;
  logic        clk, CLR, halt, btn_go, auto_mode;
  logic [31:0] display;
  logic        GO;
  logic [7:0]  seg, an;
  logic [31:0] shown;
  logic [15:0] halt_count;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  syscall_console #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(3), .AUTO_WAIT(10)) dut (
    .clk(clk), .CLR(CLR), .halt(halt), .display(display), .btn_go(btn_go),
    .auto_mode(auto_mode), .GO(GO), .seg(seg), .an(an), .shown(shown),
    .halt_count(halt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Raise btn_go for 6 cycles, watch 15 cycles; report first GO cycle and GO-high count.
  task automatic press(output int first, output int cnt);
    first = -1;
    cnt = 0;
    btn_go = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (GO === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 6) btn_go = 1'b0;
    end
  endtask

  initial begin
    int first, cnt, go_total, idx, changes, run;
    logic found;
    logic [7:0] prev_an;

    CLR = 1'b1; halt = 1'b0; btn_go = 1'b0; auto_mode = 1'b0; display = 32'h0;
    tick(); tick();
    check("rst_go", GO, 32'd0);
    check("rst_shown", shown, 32'd0);
    check("rst_count", halt_count, 32'd0);
    check("rst_an", an, 32'hFE);
    check("rst_seg", seg, 32'hC0);
    CLR = 1'b0;
    tick();

    // Halt capture: one cycle to latch.
    display = 32'h1234ABCD; halt = 1'b1;
    tick();
    check("cap_shown", shown, 32'h1234ABCD);
    check("cap_count", halt_count, 32'd1);
    display = 32'h00000000;   // must not disturb the latched word
    tick();
    prev_an = an; changes = 0; run = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      found = 1'b0; idx = 0;
      for (int j = 0; j < 8; j++)
        if (an === ~(8'd1 << j)) begin found = 1'b1; idx = j; end
      check("an_onehot", {31'd0, found}, 32'd1);
      check("seg_decode", seg, hex_tbl[(32'h1234ABCD >> (4 * idx)) & 32'hF]);
      if (idx == 0) check("seg_d0", seg, 32'hA1);
      if (idx == 7) check("seg_d7", seg, 32'hF9);
      check("halted_no_go", GO, 32'd0);
      run++;
      if (an !== prev_an) begin
        check("an_step", an, {prev_an[6:0], prev_an[7]});
        if (changes > 0) check("scan_len", run - 1, 32'd4);
        changes++;
        run = 1;
      end
      prev_an = an;
    end
    check("scan_changes", changes, 32'd10);
    check("shown_hold", shown, 32'h1234ABCD);

    // Short 2-cycle press is filtered out.
    btn_go = 1'b1; tick(); tick(); btn_go = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (GO === 1'b1) cnt++;
    end
    check("short_press", cnt, 32'd0);

    // Long press: sync 2 + debounce 3 + HALTED->RELEASE 1 => GO at cycle 6.
    press(first, cnt);
    check("go_latency", first, 32'd6);
    check("go_once", cnt, 32'd1);
    check("count_after_go", halt_count, 32'd1);

    // Halt still high: second press ignored.
    press(first, cnt);
    check("waitdrop_press", cnt, 32'd0);

    // Back-to-back episodes.
    go_total = 0;
    halt = 1'b0; tick();
    display = 32'h00000001; halt = 1'b1; tick();
    check("b2b1_count", halt_count, 32'd2);
    check("b2b1_shown", shown, 32'h00000001);
    display = 32'hDEADBEEF;
    press(first, cnt);
    go_total += cnt;
    check("b2b1_go_lat", first, 32'd6);
    halt = 1'b0; tick();
    display = 32'hFFFFFFFF; halt = 1'b1; tick();
    check("b2b2_count", halt_count, 32'd3);
    check("b2b2_shown", shown, 32'hFFFFFFFF);
    press(first, cnt);
    go_total += cnt;
    check("b2b_go_total", go_total, 32'd2);

    // Auto-run with auto_mode=1.
    halt = 1'b0; tick();
    auto_mode = 1'b1; display = 32'hCAFE0000; halt = 1'b1;
    first = -1; cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (GO === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("auto_count", halt_count, 32'd4);
`ifdef CONSOLE_AUTO_RUN_EN
    check("auto_go_lat", first, 32'd11);
    check("auto_go_once", cnt, 32'd1);
    press(first, cnt);
    check("auto_then_press", cnt, 32'd0);
`else
    check("auto_absent", cnt, 32'd0);
    press(first, cnt);
    check("auto_absent_press", first, 32'd6);
`endif

    // auto_mode=0: no release for 100 cycles, then a press works.
    auto_mode = 1'b0;
    halt = 1'b0; tick();
    display = 32'h0BADF00D; halt = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (GO === 1'b1) cnt++;
    end
    check("manual_no_go", cnt, 32'd0);
    check("manual_count", halt_count, 32'd5);
    press(first, cnt);
    check("manual_press", first, 32'd6);

    // Async reset during RELEASE.
    halt = 1'b0; tick();
    display = 32'h55AA55AA; halt = 1'b1; tick();
    check("pre_rst_count", halt_count, 32'd6);
    btn_go = 1'b1;
    repeat (6) tick();
    check("release_go", GO, 32'd1);
    #2 CLR = 1'b1;
    #1;
    check("arst_go", GO, 32'd0);
    check("arst_shown", shown, 32'd0);
    check("arst_count", halt_count, 32'd0);
    check("arst_an", an, 32'hFE);
    tick();
    check("arst_hold_count", halt_count, 32'd0);
    btn_go = 1'b0; CLR = 1'b0;
    tick();
    check("recap_count", halt_count, 32'd1);
    check("recap_shown", shown, 32'h55AA55AA);
    check("recap_go", GO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
